// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC, credit-limited fetch requests, a 2-entry
// response FIFO, and the IF/ID pipeline register that feeds decode.
module if_stage #(
  parameter logic [31:0] ResetPC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  logic [31:0] pc_reg;

  logic [31:0] aq_addr [2];
  logic        aq_wr_ptr, aq_rd_ptr;
  logic [1:0]  inflight;

  logic [31:0] fq_pc   [2];
  logic [31:0] fq_inst [2];
  logic        fq_wr_ptr, fq_rd_ptr;
  logic [1:0]  count;

  logic [31:0] id_pc_reg, id_inst_reg;

  logic        pop, accept, resp;
  logic [2:0]  credits_used;

  // Requests in flight plus buffered words may never exceed the two FIFO slots,
  // counting the slot that decode frees this cycle.
  always_comb begin
    pop          = !stall_i && (count != 2'd0);
    credits_used = {1'b0, inflight} + {1'b0, count} - {2'b00, pop};
    imem_req_o   = !rst && (credits_used < 3'd2);
  end

  assign accept      = imem_req_o && imem_ready_i;
  assign resp        = imem_rvalid_i && (inflight != 2'd0);
  assign imem_addr_o = pc_reg;
  assign id_pc_o     = id_pc_reg;
  assign id_inst_o   = id_inst_reg;

  // Queue storage carries no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (accept) begin
      aq_addr[aq_wr_ptr] <= pc_reg;
    end
    if (resp) begin
      fq_pc[fq_wr_ptr]   <= aq_addr[aq_rd_ptr];
      fq_inst[fq_wr_ptr] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= ResetPC;
      aq_wr_ptr <= 1'b0;
      aq_rd_ptr <= 1'b0;
      inflight  <= 2'd0;
    end else begin
      if (accept) begin
        pc_reg    <= pc_reg + 32'd4;
        aq_wr_ptr <= ~aq_wr_ptr;
      end
      if (resp) begin
        aq_rd_ptr <= ~aq_rd_ptr;
      end
      case ({accept, resp})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fq_wr_ptr <= 1'b0;
      fq_rd_ptr <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (resp) begin
        fq_wr_ptr <= ~fq_wr_ptr;
      end
      if (pop) begin
        fq_rd_ptr <= ~fq_rd_ptr;
      end
      case ({resp, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // An empty FIFO with decode not stalled yields a bubble (pc 0, NOP).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_reg   <= 32'd0;
      id_inst_reg <= 32'd0;
    end else if (!stall_i) begin
      if (pop) begin
        id_pc_reg   <= fq_pc[fq_rd_ptr];
        id_inst_reg <= fq_inst[fq_rd_ptr];
      end else begin
        id_pc_reg   <= 32'd0;
        id_inst_reg <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a memory model with configurable latency/ready feeds
// the main instance; a second instance checks PC wrap-around from a high reset PC.
module tb_if_stage;

  localparam logic [31:0] Key = 32'hABCD_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk, rst, stall;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, id_pc, id_inst;

  logic        stall1 = 1'b0;
  logic        ready1 = 1'b1;
  logic        req1, rvalid1;
  logic [31:0] addr1, rdata1, id_pc1, id_inst1;

  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
  int    lat_min = 1;
  int    lat_max = 1;
  int    stall_run = 0;
  int    delivered = 0;
  int    bubbles = 0;
  logic [31:0] exp_addr = 32'd0;
  exp_t  exp_q [$];
  pend_t pend [$];

  if_stage #(.ResetPC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ready_i(imem_ready),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .id_pc_o(id_pc), .id_inst_o(id_inst)
  );

  if_stage #(.ResetPC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(stall1),
    .imem_req_o(req1), .imem_addr_o(addr1), .imem_ready_i(ready1),
    .imem_rvalid_i(rvalid1), .imem_rdata_i(rdata1),
    .id_pc_o(id_pc1), .id_inst_o(id_inst1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Main memory model: drives inputs at the falling edge, samples the handshake just
  // before the rising edge, and returns addr ^ Key in request order after L cycles.
  initial begin
    int    lat;
    pend_t p;
    exp_t  e;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        stall_run   = 0;
      end else begin
        if (pend.size() != 0 && pend[0].due <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend[0].addr ^ Key;
          void'(pend.pop_front());
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = $urandom;
        end
        case (ready_mode)
          0:       imem_ready = 1'b1;
          1:       imem_ready = 1'b0;
          default: imem_ready = 1'($urandom_range(1));
        endcase
        stall_run = stall ? stall_run + 1 : 0;
        #3;
        if (ready_mode == 1) begin
          check("req_held_while_not_ready", {31'd0, imem_req}, 32'd1);
          check("addr_stable_while_not_ready", imem_addr, exp_addr);
        end
        if (stall_run >= 3 && ready_mode == 0 && lat_max == 1)
          check("req_low_during_stall", {31'd0, imem_req}, 32'd0);
        if (imem_req && imem_ready) begin
          check("accept_addr", imem_addr, exp_addr);
          e.pc   = exp_addr;
          e.inst = exp_addr ^ Key;
          exp_q.push_back(e);
          lat    = $urandom_range(lat_max, lat_min);
          p.addr = imem_addr;
          p.due  = cyc + lat;
          if (pend.size() != 0 && p.due <= pend[$].due) p.due = pend[$].due + 1;
          pend.push_back(p);
          check("outstanding_le_2", {31'd0, pend.size() <= 2}, 32'd1);
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
  end

  // Wrap instance memory: always ready, fixed latency of one cycle.
  initial begin
    logic        acc_prev = 1'b0;
    logic [31:0] addr_prev = 32'd0;
    rvalid1 = 1'b0;
    rdata1  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rvalid1  = 1'b0;
        acc_prev = 1'b0;
      end else begin
        rvalid1 = acc_prev;
        rdata1  = addr_prev ^ Key;
        #3;
        acc_prev  = req1 && ready1;
        addr_prev = addr1;
      end
    end
  end

  // Monitor: a non-stalled edge either delivers the scoreboard head or a bubble;
  // a stalled edge must leave IF/ID unchanged.
  initial begin
    logic        ps, pr;
    logic [31:0] held_pc = 32'd0;
    logic [31:0] held_inst = 32'd0;
    exp_t        e;
    forever begin
      @(posedge clk);
      ps = stall;
      pr = rst;
      @(negedge clk);
      if (!rst && !pr) begin
        if (ps) begin
          check("stall_hold_pc", id_pc, held_pc);
          check("stall_hold_inst", id_inst, held_inst);
        end else if (id_inst == 32'd0) begin
          check("bubble_pc", id_pc, 32'd0);
          bubbles++;
        end else if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_delivery: got pc %h inst %h, expected none", id_pc, id_inst);
        end else begin
          e = exp_q.pop_front();
          $display("deliver pc=%h inst=%h (expected pc=%h inst=%h)", id_pc, id_inst, e.pc, e.inst);
          check("deliver_pc", id_pc, e.pc);
          check("deliver_inst", id_inst, e.inst);
          delivered++;
        end
        held_pc   = id_pc;
        held_inst = id_inst;
      end
    end
  end

  initial begin
    logic [31:0] wrap_pc [4];
    logic [31:0] wrap_inst [4];
    int          b0, d0, i;
    wrap_pc   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    wrap_inst = '{32'h5432_FFF8, 32'h5432_FFFC, 32'hABCD_0000, 32'hABCD_0004};
    rst   = 1'b1;
    stall = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_id_pc", id_pc, 32'd0);
    check("rst_id_inst", id_inst, 32'd0);

    // Test 1 / 5: release and first-fetch latency; wrap-around on the second instance
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("req_first_cycle", {31'd0, imem_req}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 check("edge2_still_bubble", id_inst, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin
        check("edge3_first_pc", id_pc, 32'd0);
        check("edge3_first_inst", id_inst, Key);
      end
      check("wrap_pc", id_pc1, wrap_pc[k]);
      check("wrap_inst", id_inst1, wrap_inst[k]);
    end
    repeat (8) @(posedge clk);

    // Test 2: stall mid-stream for 5 cycles
    #1 stall = 1'b1;
    repeat (5) @(posedge clk);
    #1 stall = 1'b0;
    repeat (6) @(posedge clk);

    // Test 3: memory not ready for 4 cycles, FIFO drains into bubbles
    b0 = bubbles;
    #1 ready_mode = 1;
    repeat (4) @(posedge clk);
    #1 ready_mode = 0;
    check("bubbles_while_not_ready", {31'd0, bubbles > b0}, 32'd1);
    repeat (6) @(posedge clk);

    // Test 4: random latency 1..4, random ready and occasional stalls
    d0 = delivered;
    #1 ready_mode = 2;
    lat_min = 1;
    lat_max = 4;
    repeat (300) begin
      @(posedge clk);
      #1 stall = ($urandom_range(7) == 0);
    end
    stall = 1'b0;
    ready_mode = 0;
    lat_min = 1;
    lat_max = 1;
    repeat (20) @(posedge clk);
    check("random_progress", {31'd0, (delivered - d0) > 40}, 32'd1);

    // Test 6: asynchronous reset with two requests outstanding
    #1 lat_min = 4;
    lat_max = 4;
    i = 0;
    while (i < 20 && pend.size() != 2) begin
      @(posedge clk);
      i++;
    end
    check("two_outstanding_before_rst", pend.size(), 32'd2);
    check("id_busy_before_rst", {31'd0, id_inst != 32'd0}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, imem_req}, 32'd0);
    check("async_rst_id_pc", id_pc, 32'd0);
    check("async_rst_id_inst", id_inst, 32'd0);
    exp_q.delete();
    exp_addr = 32'd0;
    lat_min = 1;
    lat_max = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 check("restart_pc", id_pc, 32'd0);
    check("restart_inst", id_inst, Key);
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
